// File: rtl/adc_dft_feeder.sv
// Captures a triggered ADC burst into a FIFO and streams it to the dft block on valid/ready.
// Define ADC_OFFSET_BINARY_EN to convert offset-binary samples to two's complement on write.
module adc_dft_feeder #(
    parameter int DATA_W     = 12,
    parameter int CHUNK_N    = 32,
    parameter int CHUNKS_N   = 256,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_valid_i,
    input  logic              trig_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              valid_out_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              done_o
);
    localparam int TOTAL = CHUNK_N * CHUNKS_N;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WR_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, ACQ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] wr_data;

`ifdef ADC_OFFSET_BINARY_EN
    assign wr_data = {~adc_data_i[DATA_W-1], adc_data_i[DATA_W-2:0]};
`else
    assign wr_data = adc_data_i;
`endif

    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a write.
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && ready_i;
    assign push = (state_q == ACQ) && adc_valid_i && !full;
    assign drop = (state_q == ACQ) && adc_valid_i && full;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_cnt_d   = push ? wr_cnt_q + WR_W'(1) : wr_cnt_q;
        overflow_d = overflow_q | drop;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_i) begin
                    state_d    = ACQ;
                    wr_cnt_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            ACQ: begin
                if (push && (wr_cnt_q == WR_W'(TOTAL - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Storage needs no reset: the cleared count hides any stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign valid_out_o = (count_q != '0);
    assign data_out_o  = valid_out_o ? mem_q[rd_ptr_q] : '0;
    assign busy_o      = (state_q != IDLE);
    assign overflow_o  = overflow_q;
    assign done_o      = done_q;

endmodule
